// File: rtl/ps2_key_event_ctrl_pkg.sv
// Shared PS/2 keyboard definitions: scan codes, key indices, prefix FSM states and the key lookup.
// Game logic imports this package to decode ev_key.
package ps2_key_event_ctrl_pkg;

  localparam logic [7:0] CODE_SPACE = 8'h29;
  localparam logic [7:0] CODE_ENTER = 8'h5A;
  localparam logic [7:0] CODE_ESC   = 8'h76;
  localparam logic [7:0] CODE_UP    = 8'h75;
  localparam logic [7:0] CODE_DOWN  = 8'h72;
  localparam logic [7:0] CODE_LEFT  = 8'h6B;
  localparam logic [7:0] CODE_RIGHT = 8'h74;
  localparam logic [7:0] CODE_EXT   = 8'hE0;
  localparam logic [7:0] CODE_BRK   = 8'hF0;

  localparam int unsigned KEY_COUNT = 7;

  localparam logic [2:0] KEY_SPACE = 3'd0;
  localparam logic [2:0] KEY_ENTER = 3'd1;
  localparam logic [2:0] KEY_ESC   = 3'd2;
  localparam logic [2:0] KEY_UP    = 3'd3;
  localparam logic [2:0] KEY_DOWN  = 3'd4;
  localparam logic [2:0] KEY_LEFT  = 3'd5;
  localparam logic [2:0] KEY_RIGHT = 3'd6;

  typedef enum logic [1:0] {StIdle, StExt, StBrk, StExtBrk} prefix_state_e;

  typedef struct packed {
    logic [2:0] key;
    logic       make;
  } key_event_t;

  typedef struct packed {
    logic       hit;
    logic [2:0] idx;
  } key_hit_t;

  // Extended keys only match with the E0 prefix, base keys only without it.
  function automatic key_hit_t lookup_key(input logic [7:0] code, input logic ext);
    key_hit_t res;
    res.hit = 1'b0;
    res.idx = KEY_SPACE;
    if (!ext) begin
      case (code)
        CODE_SPACE: begin res.hit = 1'b1; res.idx = KEY_SPACE; end
        CODE_ENTER: begin res.hit = 1'b1; res.idx = KEY_ENTER; end
        CODE_ESC:   begin res.hit = 1'b1; res.idx = KEY_ESC;   end
        default:    res.hit = 1'b0;
      endcase
    end else begin
      case (code)
        CODE_UP:    begin res.hit = 1'b1; res.idx = KEY_UP;    end
        CODE_DOWN:  begin res.hit = 1'b1; res.idx = KEY_DOWN;  end
        CODE_LEFT:  begin res.hit = 1'b1; res.idx = KEY_LEFT;  end
        CODE_RIGHT: begin res.hit = 1'b1; res.idx = KEY_RIGHT; end
        default:    res.hit = 1'b0;
      endcase
    end
    return res;
  endfunction

endpackage

// File: rtl/ps2_key_event_ctrl_fifo.sv
// Key event queue: FIFO_DEPTH entries of {key, make}, valid/ready pop, drop-on-full with sticky
// overflow. Simultaneous push and pop is always accepted, even when full.
module ps2_key_event_ctrl_fifo
  import ps2_key_event_ctrl_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_push,
  input  key_event_t i_data,
  input  logic       i_ready,
  output logic       o_valid,
  output key_event_t o_data,
  output logic       o_overflow
);

  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = AW + 1;
  localparam logic [AW-1:0] PtrOne  = 1;
  localparam logic [CW-1:0] CntOne  = 1;
  localparam logic [CW-1:0] CntFull = CW'(FIFO_DEPTH);

  key_event_t    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          r_overflow;

  logic w_full;
  logic w_pop;
  logic w_push_ok;

  assign o_valid    = (r_count != '0);
  assign o_data     = r_mem[r_rd_ptr];
  assign o_overflow = r_overflow;
  assign w_full     = (r_count == CntFull);
  assign w_pop      = o_valid & i_ready;
  // When full, the slot being popped is the one written, so push-with-pop is still safe.
  assign w_push_ok  = i_push & (~w_full | w_pop);

  // Storage write; contents are don't-care while the entry is not counted.
  always_ff @(posedge i_clk) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= i_data;
  end

  // Pointers, occupancy and sticky overflow.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + PtrOne;
      if (w_pop)     r_rd_ptr <= r_rd_ptr + PtrOne;
      case ({w_push_ok, w_pop})
        2'b10:   r_count <= r_count + CntOne;
        2'b01:   r_count <= r_count - CntOne;
        default: r_count <= r_count;
      endcase
      if (i_push && !w_push_ok) r_overflow <= 1'b1;
    end
  end

endmodule

// File: rtl/ps2_key_event_ctrl.sv
// PS/2 keyboard sequencer: detects new bytes, acks the core (with re-ack on timeout), decodes the
// E0/F0 prefix stream into held-key levels and queues press/release events for game logic.
module ps2_key_event_ctrl
  import ps2_key_event_ctrl_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned ACK_TIMEOUT = 1023
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_scan_ready,
  input  logic [7:0]           i_scan_code,
  output logic                 o_read,
  output logic [KEY_COUNT-1:0] o_key_held,
  output logic                 o_ev_valid,
  output logic [2:0]           o_ev_key,
  output logic                 o_ev_make,
  input  logic                 i_ev_ready,
  output logic                 o_overflow,
  output logic                 o_protocol_err
);

  localparam logic [9:0] AckLast = 10'(ACK_TIMEOUT - 1);
  localparam logic [9:0] AckOne  = 10'd1;

  logic                 r_scan_ready_q;
  logic                 r_read;
  logic                 r_wait;
  logic [9:0]           r_ack_cnt;
  prefix_state_e        r_state;
  logic [KEY_COUNT-1:0] r_key_held;
  logic                 r_protocol_err;

  logic                 w_accept;
  logic                 w_timeout;
  logic                 w_illegal;
  logic                 w_decode;
  logic                 w_is_make;
  logic                 w_is_ext;
  key_hit_t             w_hit;
  prefix_state_e        w_next_state;
  logic [KEY_COUNT-1:0] w_key_held_d;
  logic                 w_push;
  key_event_t           w_push_data;
  key_event_t           w_head;

  assign w_accept  = i_scan_ready & ~r_scan_ready_q;
  // Core still shows the same byte ACK_TIMEOUT cycles after our ack: it missed it, ack again.
  assign w_timeout = r_wait & i_scan_ready & ~w_accept & (r_ack_cnt == AckLast);

  // Edge detect, read ack and ack-timeout counter.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_scan_ready_q <= 1'b0;
      r_read         <= 1'b0;
      r_wait         <= 1'b0;
      r_ack_cnt      <= '0;
    end else begin
      r_scan_ready_q <= i_scan_ready;
      r_read         <= w_accept | w_timeout;
      if (w_accept) begin
        r_wait    <= 1'b1;
        r_ack_cnt <= '0;
      end else if (!i_scan_ready) begin
        r_wait    <= 1'b0;
        r_ack_cnt <= '0;
      end else if (r_wait) begin
        if (w_timeout)                r_ack_cnt <= '0;
        else if (r_ack_cnt != 10'h3FF) r_ack_cnt <= r_ack_cnt + AckOne;
      end
    end
  end

  // Prefix decode of the accepted byte and resulting key_held / event push.
  always_comb begin
    w_illegal    = 1'b0;
    w_decode     = 1'b0;
    w_is_make    = 1'b1;
    w_is_ext     = 1'b0;
    w_next_state = StIdle;
    if (i_scan_code == CODE_EXT && r_state != StIdle) w_illegal = 1'b1;
    if (i_scan_code == CODE_BRK && (r_state == StBrk || r_state == StExtBrk)) w_illegal = 1'b1;
    // An illegal prefix abandons the sequence; the next byte is decoded from IDLE.
    if (!w_illegal) begin
      unique case (r_state)
        StIdle: begin
          if (i_scan_code == CODE_EXT)      w_next_state = StExt;
          else if (i_scan_code == CODE_BRK) w_next_state = StBrk;
          else w_decode = 1'b1;
        end
        StExt: begin
          if (i_scan_code == CODE_BRK) w_next_state = StExtBrk;
          else begin
            w_decode = 1'b1;
            w_is_ext = 1'b1;
          end
        end
        StBrk: begin
          w_decode  = 1'b1;
          w_is_make = 1'b0;
        end
        StExtBrk: begin
          w_decode  = 1'b1;
          w_is_make = 1'b0;
          w_is_ext  = 1'b1;
        end
        default: w_next_state = StIdle;
      endcase
    end
    w_hit        = lookup_key(i_scan_code, w_is_ext);
    w_key_held_d = r_key_held;
    w_push       = 1'b0;
    w_push_data  = '{key: w_hit.idx, make: w_is_make};
    if (w_accept && w_decode && w_hit.hit) begin
      if (w_is_make && !r_key_held[w_hit.idx]) begin
        w_key_held_d[w_hit.idx] = 1'b1;
        w_push                  = 1'b1;
      end else if (!w_is_make && r_key_held[w_hit.idx]) begin
        w_key_held_d[w_hit.idx] = 1'b0;
        w_push                  = 1'b1;
      end
    end
  end

  // Prefix FSM state, held-key levels and sticky protocol error.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state        <= StIdle;
      r_key_held     <= '0;
      r_protocol_err <= 1'b0;
    end else begin
      if (w_accept) begin
        r_state    <= w_next_state;
        r_key_held <= w_key_held_d;
      end
      if ((w_accept && w_illegal) || w_timeout) r_protocol_err <= 1'b1;
    end
  end

  ps2_key_event_ctrl_fifo #(
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .i_push    (w_push),
    .i_data    (w_push_data),
    .i_ready   (i_ev_ready),
    .o_valid   (o_ev_valid),
    .o_data    (w_head),
    .o_overflow(o_overflow)
  );

  assign o_read         = r_read;
  assign o_key_held     = r_key_held;
  assign o_ev_key       = w_head.key;
  assign o_ev_make      = w_head.make;
  assign o_protocol_err = r_protocol_err;

endmodule

// File: tb/tb_ps2_key_event_ctrl.sv
// Bench for ps2_key_event_ctrl: scoreboard of expected {key,make} events checked as they are popped.
module tb_ps2_key_event_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       scan_ready;
  logic [7:0] scan_code;
  logic       read;
  logic [6:0] key_held;
  logic       ev_valid;
  logic [2:0] ev_key;
  logic       ev_make;
  logic       ev_ready;
  logic       overflow;
  logic       protocol_err;

  int n_checks = 0;
  int n_pass   = 0;
  int n_events = 0;
  logic [3:0] sb [$];
  logic [3:0] mon_exp;

  ps2_key_event_ctrl #(
    .FIFO_DEPTH (4),
    .ACK_TIMEOUT(1023)
  ) dut (
    .i_clk         (clk),
    .i_reset       (reset),
    .i_scan_ready  (scan_ready),
    .i_scan_code   (scan_code),
    .o_read        (read),
    .o_key_held    (key_held),
    .o_ev_valid    (ev_valid),
    .o_ev_key      (ev_key),
    .o_ev_make     (ev_make),
    .i_ev_ready    (ev_ready),
    .o_overflow    (overflow),
    .o_protocol_err(protocol_err)
  );

  always #5 clk = ~clk;

  // Scoreboard monitor: every popped event must match the oldest expected one.
  always @(negedge clk) begin
    if (!reset && ev_valid && ev_ready) begin
      n_checks++;
      n_events++;
      if (sb.size() == 0) begin
        $display("FAIL ev_unexpected: got key=%0d make=%0d, required no event", ev_key, ev_make);
      end else begin
        mon_exp = sb.pop_front();
        if ({ev_key, ev_make} !== mon_exp)
          $display("FAIL ev_order: got key=%0d make=%0d, required key=%0d make=%0d",
                   ev_key, ev_make, mon_exp[3:1], mon_exp[0]);
        else n_pass++;
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1; scan_ready = 1'b0; scan_code = 8'h00; ev_ready = 1'b1;
    idle(3);
    reset = 1'b0;
    sb.delete();
  endtask

  // One byte transfer: ready high for two edges, then low for two.
  task automatic send_byte(input logic [7:0] code);
    @(posedge clk); #1;
    scan_ready = 1'b1; scan_code = code;
    @(posedge clk); #1;
    @(posedge clk); #1;
    scan_ready = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; scan_ready = 1'b0; scan_code = 8'h00; ev_ready = 1'b1;
    idle(3);
    n_checks += 5;
    if (read !== 1'b0) $display("FAIL reset_read: got %b, required 0", read); else n_pass++;
    if (key_held !== 7'h00) $display("FAIL reset_held: got %h, required 00", key_held); else n_pass++;
    if (ev_valid !== 1'b0) $display("FAIL reset_valid: got %b, required 0", ev_valid); else n_pass++;
    if (overflow !== 1'b0) $display("FAIL reset_ovf: got %b, required 0", overflow); else n_pass++;
    if (protocol_err !== 1'b0) $display("FAIL reset_err: got %b, required 0", protocol_err);
    else n_pass++;
    reset = 1'b0;
  endtask

  task automatic test_make_break();
    int ev0;
    ev0 = n_events;
    // SPACE make with explicit read-pulse timing.
    sb.push_back({3'd0, 1'b1});
    @(posedge clk); #1;
    scan_ready = 1'b1; scan_code = 8'h29;
    @(posedge clk); #1;
    n_checks += 2;
    if (read !== 1'b1) $display("FAIL read_pulse: got %b, required 1", read); else n_pass++;
    if (key_held !== 7'h01) $display("FAIL make_held: got %h, required 01", key_held); else n_pass++;
    @(posedge clk); #1;
    n_checks++;
    if (read !== 1'b0) $display("FAIL read_one_cycle: got %b, required 0", read); else n_pass++;
    scan_ready = 1'b0;
    idle(1);
    sb.push_back({3'd0, 1'b0});
    send_byte(8'hF0);
    send_byte(8'h29);
    idle(3);
    n_checks += 3;
    if (key_held !== 7'h00) $display("FAIL break_held: got %h, required 00", key_held); else n_pass++;
    if (sb.size() != 0) $display("FAIL mb_drain: got %0d pending, required 0", sb.size());
    else n_pass++;
    if (n_events - ev0 != 2) $display("FAIL mb_count: got %0d events, required 2", n_events - ev0);
    else n_pass++;
  endtask

  task automatic test_extended();
    int ev0;
    ev0 = n_events;
    sb.push_back({3'd3, 1'b1});
    send_byte(8'hE0); send_byte(8'h75);
    n_checks++;
    if (key_held !== 7'h08) $display("FAIL ext_make_held: got %h, required 08", key_held);
    else n_pass++;
    sb.push_back({3'd3, 1'b0});
    send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h75);
    // Bare 75 and the E0 12 fake shift decode to nothing.
    send_byte(8'h75);
    send_byte(8'hE0); send_byte(8'h12);
    idle(3);
    n_checks += 4;
    if (key_held !== 7'h00) $display("FAIL ext_held: got %h, required 00", key_held); else n_pass++;
    if (sb.size() != 0) $display("FAIL ext_drain: got %0d pending, required 0", sb.size());
    else n_pass++;
    if (n_events - ev0 != 2) $display("FAIL ext_count: got %0d events, required 2", n_events - ev0);
    else n_pass++;
    if (protocol_err !== 1'b0) $display("FAIL ext_err: got %b, required 0", protocol_err);
    else n_pass++;
  endtask

  task automatic test_typematic();
    int ev0;
    ev0 = n_events;
    sb.push_back({3'd0, 1'b1});
    for (int i = 0; i < 5; i++) send_byte(8'h29);
    send_byte(8'hF0); send_byte(8'h5A);
    idle(3);
    n_checks += 3;
    if (n_events - ev0 != 1) $display("FAIL typ_count: got %0d events, required 1", n_events - ev0);
    else n_pass++;
    if (key_held !== 7'h01) $display("FAIL typ_held: got %h, required 01", key_held); else n_pass++;
    if (sb.size() != 0) $display("FAIL typ_drain: got %0d pending, required 0", sb.size());
    else n_pass++;
  endtask

  task automatic test_overflow();
    int ev0;
    do_reset();
    ev0 = n_events;
    ev_ready = 1'b0;
    sb.push_back({3'd0, 1'b1}); sb.push_back({3'd1, 1'b1});
    sb.push_back({3'd2, 1'b1}); sb.push_back({3'd3, 1'b1});
    send_byte(8'h29); send_byte(8'h5A); send_byte(8'h76);
    send_byte(8'hE0); send_byte(8'h75);
    send_byte(8'hE0); send_byte(8'h72);
    idle(2);
    n_checks += 4;
    if (overflow !== 1'b1) $display("FAIL ovf_flag: got %b, required 1", overflow); else n_pass++;
    if (key_held !== 7'h1F) $display("FAIL ovf_held: got %h, required 1f", key_held); else n_pass++;
    if (ev_valid !== 1'b1) $display("FAIL ovf_valid: got %b, required 1", ev_valid); else n_pass++;
    if ({ev_key, ev_make} !== 4'b0001)
      $display("FAIL ovf_head: got key=%0d make=%0d, required key=0 make=1", ev_key, ev_make);
    else n_pass++;
    idle(3);
    n_checks++;
    if ({ev_key, ev_make} !== 4'b0001)
      $display("FAIL ovf_stable: got key=%0d make=%0d, required key=0 make=1", ev_key, ev_make);
    else n_pass++;
    ev_ready = 1'b1;
    idle(8);
    n_checks += 3;
    if (n_events - ev0 != 4) $display("FAIL ovf_count: got %0d events, required 4", n_events - ev0);
    else n_pass++;
    if (sb.size() != 0) $display("FAIL ovf_drain: got %0d pending, required 0", sb.size());
    else n_pass++;
    if (overflow !== 1'b1) $display("FAIL ovf_sticky: got %b, required 1", overflow); else n_pass++;
  endtask

  task automatic test_protocol_err();
    do_reset();
    sb.push_back({3'd0, 1'b1});
    send_byte(8'hF0); send_byte(8'hF0); send_byte(8'h29);
    idle(3);
    n_checks += 3;
    if (protocol_err !== 1'b1) $display("FAIL perr_flag: got %b, required 1", protocol_err);
    else n_pass++;
    if (key_held !== 7'h01) $display("FAIL perr_held: got %h, required 01", key_held); else n_pass++;
    if (sb.size() != 0) $display("FAIL perr_drain: got %0d pending, required 0", sb.size());
    else n_pass++;
  endtask

  task automatic test_ack_timeout();
    int pulses;
    int ev0;
    do_reset();
    ev0 = n_events;
    pulses = 0;
    sb.push_back({3'd1, 1'b1});
    @(posedge clk); #1;
    scan_ready = 1'b1; scan_code = 8'h5A;
    for (int i = 0; i < 1100; i++) begin
      @(posedge clk); #1;
      if (read) pulses++;
    end
    scan_ready = 1'b0;
    idle(3);
    n_checks += 3;
    if (pulses != 2) $display("FAIL tmo_pulses: got %0d, required 2", pulses); else n_pass++;
    if (protocol_err !== 1'b1) $display("FAIL tmo_err: got %b, required 1", protocol_err);
    else n_pass++;
    if (n_events - ev0 != 1) $display("FAIL tmo_count: got %0d events, required 1", n_events - ev0);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    int ev0;
    do_reset();
    send_byte(8'hE0);
    do_reset();
    ev0 = n_events;
    send_byte(8'h75);
    idle(3);
    n_checks += 5;
    if (n_events - ev0 != 0) $display("FAIL rmid_count: got %0d events, required 0", n_events - ev0);
    else n_pass++;
    if (key_held !== 7'h00) $display("FAIL rmid_held: got %h, required 00", key_held); else n_pass++;
    if (ev_valid !== 1'b0) $display("FAIL rmid_valid: got %b, required 0", ev_valid); else n_pass++;
    if (protocol_err !== 1'b0) $display("FAIL rmid_err: got %b, required 0", protocol_err);
    else n_pass++;
    if (overflow !== 1'b0) $display("FAIL rmid_ovf: got %b, required 0", overflow); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_make_break();
    test_extended();
    test_typematic();
    test_overflow();
    test_protocol_err();
    test_ack_timeout();
    test_reset_mid();
    idle(2);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
